spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
SPI master transfer sequencer between a TX FIFO and an RX FIFO.
- Pops words from the TX FIFO, shifts them out MSB-first in SPI mode 0, and samples MISO in parallel.
- Pushes each received word into the RX FIFO.
- Keeps CS asserted across back-to-back words while TX data is available.
- Sits between the register interface's FIFO pair and the SPI pins.

Parameters:
DATA_WIDTH, 24, bits per SPI word; must equal the FIFO word width.
CLK_DIV, 4, clk_i cycles per SCLK half-period; minimum 1.
CS_GAP, 2, minimum clk_i cycles CS stays deasserted between bursts.

Ports:
clk_i  in  1  system clock; all logic on rising edge.
rst_i  in  1  reset; asynchronous, active-high.
en_i  in  1  allow new words to start.
tx_empty_i  in  1  TX FIFO empty flag.
tx_rd_o  out  1  TX FIFO pop strobe, one cycle.
tx_data_i  in  DATA_WIDTH  TX FIFO registered read data; valid the cycle after tx_rd_o.
rx_full_i  in  1  RX FIFO full flag.
rx_wr_o  out  1  RX FIFO push strobe, one cycle.
rx_data_o  out  DATA_WIDTH  received word; valid when rx_wr_o=1.
spi_sclk_o  out  1  SPI clock; idles low.
spi_mosi_o  out  1  SPI data out.
spi_miso_i  in  1  SPI data in.
spi_cs_no  out  1  chip select, active-low.
busy_o  out  1  high in every state except IDLE.
done_o  out  1  one-cycle pulse, coincident with rx_wr_o.

Behaviour:
Reset:
- Applies immediately, including mid-word.
- Outputs: tx_rd_o=0, rx_wr_o=0, done_o=0, busy_o=0, spi_sclk_o=0, spi_mosi_o=0, spi_cs_no=1, rx_data_o=0.
- All counters cleared; FSM goes to IDLE.
- The partial word is discarded and no RX push occurs.

FSM states: IDLE, FETCH, LOAD, SHIFT, STORE, GAP.
- IDLE -> FETCH when en_i && !tx_empty_i.
- FETCH: tx_rd_o=1 for exactly one cycle; then LOAD.
- LOAD:
  - Capture tx_data_i into the TX shift register.
  - Drive spi_cs_no=0 and spi_mosi_o = tx_data_i[DATA_WIDTH-1].
  - Clear the divider and bit counter; then SHIFT.
- SHIFT:
  - Divider counts 0..CLK_DIV-1; at terminal count spi_sclk_o toggles.
  - Rising SCLK edge: shift spi_miso_i into the RX shift register LSB.
  - Falling SCLK edge: shift TX left and present the next bit on MOSI.
  - After the DATA_WIDTH-th falling edge (SCLK back low), go to STORE.
  - MOSI does not change after the last falling edge.
- STORE:
  - If !rx_full_i: rx_wr_o=1 and done_o=1 for one cycle, rx_data_o = RX shift register.
  - Next state: FETCH if en_i && !tx_empty_i (CS stays low, burst continues); otherwise GAP.
  - If rx_full_i: stay in STORE with SCLK low and CS low, no push. Words are never dropped.
- GAP: spi_cs_no=1; hold CS_GAP cycles; then IDLE.

Timing:
- First rising SCLK edge occurs CLK_DIV cycles after entering SHIFT.
- Word latency with RX not full: FETCH(1) + LOAD(1) + 2*DATA_WIDTH*CLK_DIV + STORE(1).
- en_i deassert mid-word: the current word completes and is stored; no new FETCH.
- tx_empty_i is sampled only in IDLE and STORE.

Optional Feature:
SPI_LOOPBACK_EN:
- Defined: the RX shift register samples the internal MOSI value instead of spi_miso_i; spi_miso_i is ignored; pins behave otherwise unchanged.
- Undefined: spi_miso_i is sampled.

Decomposition:
- Package spi_pkg:
  - typedef enum spi_ctrl_state_e {IDLE, FETCH, LOAD, SHIFT, STORE, GAP}.
  - localparam SPI_WORD_WIDTH = 24.
- Sub-module spi_sclk_gen:
  - Contains the CLK_DIV divider and SCLK toggle flop.
  - Outputs rise_stb/fall_stb and sclk; enabled only in SHIFT.

Test Plan:
- Single word, loopback: DATA_WIDTH=24, CLK_DIV=2, TX holds 24'hA5C3F0, en_i=1 -> one tx_rd_o pulse, 24 SCLK periods, rx_data_o=24'hA5C3F0 with rx_wr_o/done_o pulsed once, CS low 1+96+1 cycles, then GAP and CS high.
- MISO pattern: spi_miso_i driven 24'h123456 MSB-first on falling edges -> rx_data_o=24'h123456; MOSI bit sequence matches the TX word.
- Burst: three words queued -> CS stays low across all three, exactly 3 tx_rd_o and 3 rx_wr_o pulses, a single GAP at the end.
- RX backpressure: rx_full_i=1 at STORE for 10 cycles -> no rx_wr_o, SCLK low, CS low; push occurs the cycle after rx_full_i falls, with data intact.
- Reset mid-SHIFT: assert rst_i after bit 7 -> same-cycle spi_cs_no=1, sclk=0, busy_o=0; no rx_wr_o; a later transfer is correct.
- Enable drop: en_i=0 during word 1 of 2 queued -> word 1 completes and is stored, word 2 is not fetched (tx_rd_o count = 1).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI transfer sequencer: controller state encoding and default word width.
package spi_pkg;

    localparam int SPI_WORD_WIDTH = 24;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        STORE,
        GAP
    } spi_ctrl_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: CLK_DIV-cycle half-period divider and the SCLK toggle flop.
// Strobes flag the clk edge on which SCLK will rise or fall; held idle-low while disabled.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             term;

    assign term     = (div == DIV_LAST);
    assign rise_stb = en && term && !sclk;
    assign fall_stb = en && term && sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            div  <= '0;
            sclk <= 1'b0;
        end else if (term) begin
            div  <= '0;
            sclk <= ~sclk;
        end else begin
            div  <= div + 1'b1;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master sequencer between a TX FIFO and an RX FIFO; CS held low across back-to-back words.
// Build option: define SPI_LOOPBACK_EN to sample the internal MOSI instead of spi_miso_i.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_WORD_WIDTH,
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  tx_empty_i,
    output logic                  tx_rd_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  rx_full_i,
    output logic                  rx_wr_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  spi_sclk_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i,
    output logic                  spi_cs_no,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (CS_GAP > 1) ? GAP_W'(CS_GAP - 1) : '0;

    spi_ctrl_state_e       state;
    logic [BIT_W-1:0]      bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DATA_WIDTH-2:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_bit;
    logic                  shift_en;
    logic                  rise_stb;
    logic                  fall_stb;
    logic                  last_bit;

    assign shift_en = (state == SHIFT);
    assign last_bit = (bit_cnt == BIT_LAST);

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = spi_miso_i;
    assign rx_bit      = spi_mosi_o;
`else
    assign rx_bit      = spi_miso_i;
`endif

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk_i),
        .rst      (rst_i),
        .en       (shift_en),
        .sclk     (spi_sclk_o),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Shift registers carry only data; a reset mid-word leaves them stale but they are fully
    // refilled before the next push, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (state == LOAD) begin
            tx_shift <= tx_data_i[DATA_WIDTH-2:0];
        end else if (fall_stb && !last_bit) begin
            tx_shift <= {tx_shift[DATA_WIDTH-3:0], 1'b0};
        end
        if (rise_stb) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], rx_bit};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            tx_rd_o    <= 1'b0;
            rx_wr_o    <= 1'b0;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
            spi_mosi_o <= 1'b0;
            spi_cs_no  <= 1'b1;
            rx_data_o  <= '0;
        end else begin
            tx_rd_o <= 1'b0;
            rx_wr_o <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i && !tx_empty_i) begin
                        state   <= FETCH;
                        tx_rd_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                FETCH: begin
                    state     <= LOAD;
                    spi_cs_no <= 1'b0;
                end
                LOAD: begin
                    spi_mosi_o <= tx_data_i[DATA_WIDTH-1];
                    bit_cnt    <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    // MOSI is frozen on the last falling edge so the final bit stays on the pin.
                    if (fall_stb) begin
                        if (last_bit) begin
                            state <= STORE;
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            spi_mosi_o <= tx_shift[DATA_WIDTH-2];
                        end
                    end
                end
                STORE: begin
                    if (!rx_full_i) begin
                        rx_wr_o   <= 1'b1;
                        done_o    <= 1'b1;
                        rx_data_o <= rx_shift;
                        if (en_i && !tx_empty_i) begin
                            state   <= FETCH;
                            tx_rd_o <= 1'b1;
                        end else begin
                            state     <= GAP;
                            spi_cs_no <= 1'b1;
                            gap_cnt   <= '0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: FIFO models, a mode-0 SPI slave and a word-level reference of the transfers.
// Honours SPI_LOOPBACK_EN when choosing the expected received word.
module tb_spi_xfer_ctrl;

    localparam int DW  = 24;
    localparam int CD  = 2;
    localparam int GAP = 2;
    localparam int WORD_CYC = 2 * DW * CD;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_i = 1'b0;
    logic          tx_empty_i;
    logic          tx_rd_o;
    logic [DW-1:0] tx_data_i;
    logic          rx_full_i = 1'b0;
    logic          rx_wr_o;
    logic [DW-1:0] rx_data_o;
    logic          spi_sclk_o;
    logic          spi_mosi_o;
    logic          spi_miso_i;
    logic          spi_cs_no;
    logic          busy_o;
    logic          done_o;

    spi_xfer_ctrl #(
        .DATA_WIDTH (DW),
        .CLK_DIV    (CD),
        .CS_GAP     (GAP)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .tx_empty_i (tx_empty_i),
        .tx_rd_o    (tx_rd_o),
        .tx_data_i  (tx_data_i),
        .rx_full_i  (rx_full_i),
        .rx_wr_o    (rx_wr_o),
        .rx_data_o  (rx_data_o),
        .spi_sclk_o (spi_sclk_o),
        .spi_mosi_o (spi_mosi_o),
        .spi_miso_i (spi_miso_i),
        .spi_cs_no  (spi_cs_no),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // TX FIFO model with registered read data
    logic [DW-1:0] tx_mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign tx_empty_i = (rd_ptr == wr_ptr);

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr    <= 0;
            tx_data_i <= '0;
        end else if (tx_rd_o && rd_ptr != wr_ptr) begin
            tx_data_i <= tx_mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push_tx(input logic [DW-1:0] w);
        tx_mem[wr_ptr % 16] = w;
        wr_ptr++;
    endtask

    // Mode-0 slave: captures MOSI on rising SCLK, advances its MISO bit on falling SCLK
    logic [DW-1:0] miso_words [0:7];
    logic [DW-1:0] mosi_acc;
    logic [DW-1:0] mosi_q [$];
    logic [DW-1:0] miso_cur;
    int bitidx = 0;
    int widx = 0;

    assign miso_cur   = miso_words[widx % 8];
    assign spi_miso_i = miso_cur[DW-1-bitidx];

    always @(posedge spi_sclk_o or negedge spi_sclk_o or posedge rst_i) begin
        if (rst_i) begin
            bitidx   = 0;
            widx     = 0;
            mosi_acc = '0;
        end else if (spi_sclk_o) begin
            mosi_acc = {mosi_acc[DW-2:0], spi_mosi_o};
        end else begin
            bitidx = bitidx + 1;
            if (bitidx == DW) begin
                mosi_q.push_back(mosi_acc);
                bitidx = 0;
                widx   = widx + 1;
            end
        end
    end

    // Event monitor
    int cyc = 0;
    int n_rd, n_wr, n_done_bad, n_cs_rise, cs_low, t_rd, t_wr;
    logic cs_prev = 1'b1;
    logic mosi_at_wr;
    logic [DW-1:0] rx_q [$];

    always @(negedge clk_i) begin
        cyc++;
        if (rst_i) begin
            cs_prev = 1'b1;
        end else begin
            if (tx_rd_o) begin
                n_rd++;
                if (t_rd < 0) t_rd = cyc;
            end
            if (rx_wr_o) begin
                n_wr++;
                rx_q.push_back(rx_data_o);
                mosi_at_wr = spi_mosi_o;
                if (t_wr < 0) t_wr = cyc;
            end
            if (done_o !== rx_wr_o) n_done_bad++;
            if (!spi_cs_no) cs_low++;
            if (spi_cs_no && !cs_prev) n_cs_rise++;
            cs_prev = spi_cs_no;
        end
    end

    logic rand_full = 1'b0;
    always @(negedge clk_i) if (rand_full) rx_full_i = ($urandom_range(0, 2) == 0);

    function automatic logic [DW-1:0] exp_rx(input logic [DW-1:0] t, input logic [DW-1:0] m);
`ifdef SPI_LOOPBACK_EN
        return t;
`else
        return m;
`endif
    endfunction

    function automatic logic [DW-1:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : '1;
    endfunction

    function automatic logic [DW-1:0] mosi_at(input int i);
        return (i < mosi_q.size()) ? mosi_q[i] : '1;
    endfunction

    logic [DW-1:0] tw [0:7];
    logic [DW-1:0] mw [0:7];

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_i);
            #1;
        end
    endtask

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; n_done_bad = 0; n_cs_rise = 0; cs_low = 0;
        t_rd = -1; t_wr = -1;
        rx_q.delete();
        mosi_q.delete();
    endtask

    task automatic apply_reset();
        rst_i     = 1'b1;
        en_i      = 1'b0;
        rand_full = 1'b0;
        rx_full_i = 1'b0;
        wr_ptr    = 0;
        tick(2);
        rst_i = 1'b0;
        tick(1);
        clear_stats();
    endtask

    task automatic wait_rd(input int k, input int budget);
        for (int i = 0; i < budget && n_rd < k; i++) tick(1);
        chk("wait_rd", n_rd, k);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy_o; i++) tick(1);
        chk("idle_busy", busy_o, 0);
    endtask

    task automatic run_words(input int n);
        en_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            miso_words[i] = mw[i];
            push_tx(tw[i]);
        end
        en_i = 1'b1;
        for (int i = 0; i < n * 200 + 100 && n_wr < n; i++) tick(1);
        wait_idle(100);
        chk("n_wr", n_wr, n);
        chk("n_rd", n_rd, n);
        chk("done_eq_wr", n_done_bad, 0);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("rx_word%0d", i), rx_at(i), exp_rx(tw[i], mw[i]));
            chk($sformatf("mosi_word%0d", i), mosi_at(i), tw[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) miso_words[i] = '0;
        tick(3);
        chk("rst_tx_rd", tx_rd_o, 0);
        chk("rst_rx_wr", rx_wr_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sclk", spi_sclk_o, 0);
        chk("rst_mosi", spi_mosi_o, 0);
        chk("rst_cs", spi_cs_no, 1);
        chk("rst_rx_data", rx_data_o, 0);

        // single word with fixed pattern
        apply_reset();
        tw[0] = 24'hA5C3F0;
        mw[0] = 24'h123456;
        run_words(1);
        chk("single_cs_low", cs_low, WORD_CYC + 2);
        chk("single_latency", t_wr - t_rd, WORD_CYC + 3);
        chk("single_cs_bursts", n_cs_rise, 1);
        chk("single_mosi_hold", mosi_at_wr, tw[0][0]);

        // three-word burst
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            tw[i] = DW'($urandom);
            mw[i] = DW'($urandom);
        end
        run_words(3);
        chk("burst_cs_low", cs_low, 3 * (WORD_CYC + 3) - 1);
        chk("burst_cs_bursts", n_cs_rise, 1);

        // RX backpressure held in STORE
        apply_reset();
        tw[0] = DW'($urandom);
        mw[0] = DW'($urandom);
        miso_words[0] = mw[0];
        push_tx(tw[0]);
        rx_full_i = 1'b1;
        en_i = 1'b1;
        wait_rd(1, 50);
        tick(WORD_CYC + 2 + 10);
        chk("bp_no_wr", n_wr, 0);
        chk("bp_sclk", spi_sclk_o, 0);
        chk("bp_cs", spi_cs_no, 0);
        chk("bp_busy", busy_o, 1);
        rx_full_i = 1'b0;
        en_i = 1'b0;
        tick(1);
        chk("bp_wr", rx_wr_o, 1);
        chk("bp_data", rx_data_o, exp_rx(tw[0], mw[0]));
        wait_idle(50);
        chk("bp_n_wr", n_wr, 1);

        // reset in the middle of a word
        apply_reset();
        tw[0] = DW'($urandom);
        mw[0] = DW'($urandom);
        miso_words[0] = mw[0];
        push_tx(tw[0]);
        en_i = 1'b1;
        wait_rd(1, 50);
        tick(1 + 7 * 2 * CD + CD + 2);
        chk("mid_sclk_high", spi_sclk_o, 1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_cs", spi_cs_no, 1);
        chk("mid_rst_sclk", spi_sclk_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_wr", rx_wr_o, 0);
        chk("mid_rst_mosi", spi_mosi_o, 0);
        wr_ptr = 0;
        en_i = 1'b0;
        tick(2);
        rst_i = 1'b0;
        tick(1);
        chk("mid_rst_no_push", n_wr, 0);
        clear_stats();
        tw[0] = DW'($urandom);
        mw[0] = DW'($urandom);
        run_words(1);

        // enable dropped during word 1 of 2
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            tw[i] = DW'($urandom);
            mw[i] = DW'($urandom);
            miso_words[i] = mw[i];
            push_tx(tw[i]);
        end
        en_i = 1'b1;
        wait_rd(1, 50);
        en_i = 1'b0;
        wait_idle(WORD_CYC + 50);
        tick(20);
        chk("endrop_n_rd", n_rd, 1);
        chk("endrop_n_wr", n_wr, 1);
        chk("endrop_data", rx_at(0), exp_rx(tw[0], mw[0]));
        chk("endrop_tx_left", tx_empty_i, 0);

        // randomized bursts, odd iterations with random RX backpressure
        for (int it = 0; it < 6; it++) begin
            int n;
            apply_reset();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                tw[i] = DW'($urandom);
                mw[i] = DW'($urandom);
            end
            rand_full = (it % 2 == 1);
            run_words(n);
            rand_full = 1'b0;
            rx_full_i = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
